// File: rtl/data_ram_bridge_pkg.sv
// Shared definitions for the word-to-byte SRAM bridge.
// Holds bus widths, FSM encodings and lane ordering constants.
package data_ram_bridge_pkg;

  localparam int unsigned RegBus  = 32;
  localparam int unsigned ByteBus = 8;
  localparam int unsigned LaneNum = 4;
  localparam int unsigned LaneW   = 2;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // Lanes are walked from the most significant byte down (big-endian).
  localparam logic [LaneW-1:0] LaneFirst = 2'd3;
  localparam logic [LaneW-1:0] LaneLast  = 2'd0;

  // Byte offset within the word for a given lane: lane 3 sits at +0.
  function automatic logic [LaneW-1:0] lane_offset(input logic [LaneW-1:0] lane);
    return LaneFirst - lane;
  endfunction

endpackage

// File: rtl/mem_lane_pick.sv
// Priority encoder over pending byte lanes; the highest pending lane wins.
// Also flags whether any lane is pending and whether this is the final one.
module mem_lane_pick
  import data_ram_bridge_pkg::*;
(
  input  logic [LaneNum-1:0] pend_i,
  output logic [LaneW-1:0]   lane_o,
  output logic               any_o,
  output logic               last_o
);

  logic [LaneNum-1:0] pend_minus_one;

  always_comb begin
    lane_o = '0;
    // Later iterations override earlier ones, so the top pending lane wins.
    for (int i = 0; i < int'(LaneNum); i++) begin
      if (pend_i[i]) begin
        lane_o = LaneW'(i);
      end
    end
  end

  assign pend_minus_one = pend_i - LaneNum'(1);
  assign any_o          = |pend_i;
  assign last_o         = any_o && ((pend_i & pend_minus_one) == '0);

endmodule

// File: rtl/data_ram_bridge.sv
// Splits a 32-bit core memory request into byte accesses on an 8-bit SRAM,
// one selected lane per cycle, big-endian, stalling the core until done.
module data_ram_bridge
  import data_ram_bridge_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ram_ce_i,
  input  logic                ram_we_i,
  input  logic [RegBus-1:0]   ram_addr_i,
  input  logic [LaneNum-1:0]  ram_sel_i,
  input  logic [RegBus-1:0]   ram_data_i,
  output logic [RegBus-1:0]   ram_data_o,
  output logic                stallreq_o,
  output logic                ext_ce_o,
  output logic                ext_we_o,
  output logic [RegBus-1:0]   ext_addr_o,
  output logic [ByteBus-1:0]  ext_data_o,
  input  logic [ByteBus-1:0]  ext_data_i
);

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [RegBus-3:0]  addr_q, addr_d;
  logic [LaneNum-1:0] pend_q, pend_d;
  logic [RegBus-1:0]  wdata_q, wdata_d;
  logic [RegBus-1:0]  rdata_q, rdata_d;
  logic               cap_q, cap_d;
  logic [LaneW-1:0]   cap_lane_q, cap_lane_d;
  logic               first_q, first_d;
  logic               stall;

  logic [LaneW-1:0]   pick_lane;
  logic               pick_any;
  logic               pick_last;

  logic               unused_addr_lsb;
  assign unused_addr_lsb = ^ram_addr_i[1:0];

  mem_lane_pick u_lane_pick (
    .pend_i (pend_q),
    .lane_o (pick_lane),
    .any_o  (pick_any),
    .last_o (pick_last)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    cap_d      = 1'b0;
    cap_lane_d = cap_lane_q;
    first_d    = first_q;
    stall      = 1'b0;
    ext_ce_o   = 1'b0;
    ext_we_o   = 1'b0;
    ext_addr_o = '0;
    ext_data_o = '0;

    // SRAM read data arrives the cycle after issue; first capture clears stale bytes.
    if (cap_q) begin
      if (first_q) begin
        rdata_d = '0;
      end
      rdata_d[{cap_lane_q, 3'b000} +: ByteBus] = ext_data_i;
      first_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (ram_ce_i) begin
          stall   = 1'b1;
          we_d    = ram_we_i;
          addr_d  = ram_addr_i[RegBus-1:2];
          pend_d  = ram_sel_i;
          wdata_d = ram_data_i;
          first_d = ~ram_we_i;
          state_d = (ram_sel_i == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        stall      = 1'b1;
        ext_ce_o   = 1'b1;
        ext_we_o   = we_q;
        ext_addr_o = {addr_q, 2'b00} + RegBus'(lane_offset(pick_lane));
        ext_data_o = wdata_q[{pick_lane, 3'b000} +: ByteBus];
        pend_d[pick_lane] = 1'b0;
        cap_d      = ~we_q;
        cap_lane_d = pick_lane;
        if (pick_last || !pick_any) begin
          state_d = we_q ? StDone : StDrain;
        end
      end
      StDrain: begin
        stall   = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign stallreq_o = stall & ~rst;
  assign ram_data_o = rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      pend_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cap_q      <= 1'b0;
      cap_lane_q <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cap_q      <= cap_d;
      cap_lane_q <= cap_lane_d;
      first_q    <= first_d;
    end
  end

endmodule

// File: tb/tb_data_ram_bridge.sv
// Directed bench for data_ram_bridge: byte SRAM model, issue log and
// hand-computed expectations for loads, stores, sparse, empty and reset cases.
module tb_data_ram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_ce_i;
  logic        ram_we_i;
  logic [31:0] ram_addr_i;
  logic [3:0]  ram_sel_i;
  logic [31:0] ram_data_i;
  logic [31:0] ram_data_o;
  logic        stallreq_o;
  logic        ext_ce_o;
  logic        ext_we_o;
  logic [31:0] ext_addr_o;
  logic [7:0]  ext_data_o;
  logic [7:0]  ext_data_i;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [256];
  logic [31:0] log_addr [$];
  logic [7:0]  log_data [$];
  logic        log_we   [$];

  always #5 clk = ~clk;

  data_ram_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .ram_ce_i   (ram_ce_i),
    .ram_we_i   (ram_we_i),
    .ram_addr_i (ram_addr_i),
    .ram_sel_i  (ram_sel_i),
    .ram_data_i (ram_data_i),
    .ram_data_o (ram_data_o),
    .stallreq_o (stallreq_o),
    .ext_ce_o   (ext_ce_o),
    .ext_we_o   (ext_we_o),
    .ext_addr_o (ext_addr_o),
    .ext_data_o (ext_data_o),
    .ext_data_i (ext_data_i)
  );

  // Byte SRAM: synchronous write, read data registered one cycle after issue.
  always @(posedge clk) begin
    if (ext_ce_o === 1'b1) begin
      if (ext_we_o) mem[ext_addr_o[7:0]] <= ext_data_o;
      else          ext_data_i <= mem[ext_addr_o[7:0]];
    end
  end

  always @(negedge clk) begin
    if (ext_ce_o === 1'b1) begin
      log_addr.push_back(ext_addr_o);
      log_data.push_back(ext_data_o);
      log_we.push_back(ext_we_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issues one request and counts stall cycles; returns in the DONE cycle with ce still high.
  task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] data, output int stalls);
    log_addr.delete();
    log_data.delete();
    log_we.delete();
    @(negedge clk);
    ram_ce_i   = 1'b1;
    ram_we_i   = we;
    ram_addr_i = addr;
    ram_sel_i  = sel;
    ram_data_i = data;
    #1;
    stalls = 0;
    while (stallreq_o === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ram_ce_i = 1'b0;
    end
    #1;
  endtask

  int st;
  logic [7:0] exp_b [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst        = 1'b1;
    ram_ce_i   = 1'b1;
    ram_we_i   = 1'b0;
    ram_addr_i = '0;
    ram_sel_i  = 4'hF;
    ram_data_i = '0;
    ext_data_i = '0;

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("stall_in_reset", {31'b0, stallreq_o}, 32'h0);
    ram_ce_i = 1'b0;
    #1;
    chk("rst_ram_data", ram_data_o, 32'h0);
    chk("rst_ext_ce", {31'b0, ext_ce_o}, 32'h0);
    chk("rst_ext_we", {31'b0, ext_we_o}, 32'h0);
    chk("rst_ext_addr", ext_addr_o, 32'h0);
    chk("rst_ext_data", {24'b0, ext_data_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // The SRAM model uses an 8-bit index, so 0x100 aliases 0x00 and 0x201 aliases 0x01.
    mem[8'h00] = 8'hAA; mem[8'h01] = 8'hBB; mem[8'h02] = 8'hCC; mem[8'h03] = 8'hDD;

    // Full-word load.
    req(1'b0, 32'h100, 4'hF, 32'h0, st);
    chk("load_stalls", st, 6);
    chk("load_data", ram_data_o, 32'hAABBCCDD);
    chk("load_issues", log_addr.size(), 4);
    chk("load_addr0", log_addr[0], 32'h100);
    chk("load_addr3", log_addr[3], 32'h103);
    chk("load_we", {31'b0, log_we[0]}, 32'h0);

    // Full-word store; load data must be untouched.
    req(1'b1, 32'h100, 4'hF, 32'h11223344, st);
    chk("store_stalls", st, 5);
    chk("store_issues", log_addr.size(), 4);
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("store_addr%0d", i), log_addr[i], 32'h100 + i);
      chk($sformatf("store_byte%0d", i), {24'b0, log_data[i]}, {24'b0, exp_b[i]});
      chk($sformatf("store_we%0d", i), {31'b0, log_we[i]}, 32'h1);
    end
    chk("store_keeps_rdata", ram_data_o, 32'hAABBCCDD);
    idle(1);
    chk("store_mem_last", {24'b0, mem[8'h03]}, 32'h44);

    // Sparse byte load: lane 2 of word 0x200 lives at 0x201.
    mem[8'h01] = 8'h5A;
    req(1'b0, 32'h202, 4'b0100, 32'h0, st);
    chk("sparse_stalls", st, 3);
    chk("sparse_issues", log_addr.size(), 1);
    chk("sparse_addr", log_addr[0], 32'h201);
    chk("sparse_data", ram_data_o, 32'h005A0000);

    // Empty request: single stall, no SRAM traffic, ce held in DONE starts nothing.
    req(1'b1, 32'h300, 4'b0000, 32'hFFFFFFFF, st);
    chk("empty_stalls", st, 1);
    idle(3);
    chk("empty_issues", log_addr.size(), 0);
    chk("empty_keeps_rdata", ram_data_o, 32'h005A0000);

    // Two-lane store, lanes 3 and 1 of word 0x20.
    req(1'b1, 32'h21, 4'b1010, 32'hA1B2C3D4, st);
    chk("mixed_stalls", st, 3);
    chk("mixed_issues", log_addr.size(), 2);
    chk("mixed_addr0", log_addr[0], 32'h20);
    chk("mixed_byte0", {24'b0, log_data[0]}, 32'hA1);
    chk("mixed_addr1", log_addr[1], 32'h22);
    chk("mixed_byte1", {24'b0, log_data[1]}, 32'hC3);
    idle(1);
    chk("mixed_skip_lane", {24'b0, mem[8'h21]}, 32'h0);

    // Back-to-back store then load of the same word.
    req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, st);
    chk("b2b_store_stalls", st, 5);
    req(1'b0, 32'h10, 4'hF, 32'h0, st);
    chk("b2b_load_stalls", st, 6);
    chk("b2b_load_data", ram_data_o, 32'hDEADBEEF);
    idle(1);

    // Reset during the second ISSUE cycle of a store.
    mem[8'h40] = 8'hEE; mem[8'h41] = 8'hEE; mem[8'h42] = 8'hEE; mem[8'h43] = 8'hEE;
    log_addr.delete();
    log_data.delete();
    log_we.delete();
    @(negedge clk);
    ram_ce_i   = 1'b1;
    ram_we_i   = 1'b1;
    ram_addr_i = 32'h40;
    ram_sel_i  = 4'hF;
    ram_data_i = 32'h01020304;
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    ram_ce_i = 1'b0;
    #1;
    chk("midrst_stall", {31'b0, stallreq_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ext_ce", {31'b0, ext_ce_o}, 32'h0);
    chk("midrst_stall_after", {31'b0, stallreq_o}, 32'h0);
    chk("midrst_rdata", ram_data_o, 32'h0);
    idle(4);
    chk("midrst_issues", log_addr.size(), 2);
    chk("midrst_first_byte", {24'b0, mem[8'h40]}, 32'h01);
    chk("midrst_byte2", {24'b0, mem[8'h42]}, 32'hEE);
    chk("midrst_byte3", {24'b0, mem[8'h43]}, 32'hEE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram_bridge.md
DATA_RAM_BRIDGE -- requirements
Module: data_ram_bridge

Interface
REQ-001 SHALL use one clock and synchronous active-high reset. clk is the single clock; rst is synchronous and active-high.
REQ-002 SHALL have these ports, in order:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- ram_ce_i, input, 1, request valid from the core MEM stage.
- ram_we_i, input, 1, 1 = store, 0 = load.
- ram_addr_i, input, 32, byte address; bits [1:0] are ignored.
- ram_sel_i, input, 4, byte-lane enables.
- ram_data_i, input, 32, store data.
- ram_data_o, output, 32, load data returned to the core.
- stallreq_o, output, 1, stall request to ctrl.
- ext_ce_o, output, 1, byte SRAM enable.
- ext_we_o, output, 1, byte SRAM write enable.
- ext_addr_o, output, 32, byte SRAM address.
- ext_data_o, output, 8, byte SRAM write data.
- ext_data_i, input, 8, byte SRAM read data; valid one cycle after a read issue.
REQ-003 SHALL fix byte order as big-endian:
- sel[3] / bits 31:24 map to {addr[31:2],2'b00}+0.
- sel[0] / bits 7:0 map to +3.

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-005 SHALL, in IDLE with ram_ce_i=1, register we, word address, sel and data, then go to ISSUE. If sel=4'b0000, it goes to DONE instead.
REQ-006 SHALL drive stallreq_o = (IDLE & ram_ce_i) | ISSUE | DRAIN, combinationally. stallreq_o SHALL be 0 in DONE.
REQ-007 SHALL, in ISSUE, access exactly one still-pending selected lane per cycle. Lanes are taken in order 3,2,1,0 and unselected lanes are skipped.
REQ-008 SHALL assert ext_ce_o=1 only in ISSUE. In that cycle:
- ext_we_o = registered we.
- ext_addr_o = word address + lane offset.
- ext_data_o = the corresponding store byte.
REQ-009 SHALL, on a load, capture ext_data_i into the matching ram_data_o byte in the cycle after each issue. Unselected bytes SHALL read 0.
REQ-010 SHALL transition after the last selected lane is issued:
- Store: ISSUE → DONE.
- Load: ISSUE → DRAIN (final capture) → DONE.
REQ-011 SHALL go DONE → IDLE unconditionally. A ram_ce_i still high in DONE belongs to the completed request and SHALL NOT start a new access.
REQ-012 SHALL meet these latencies, with N = number of selected lanes: store stalls N+1 cycles; load stalls N+2 cycles. The following cycle is DONE.
REQ-013 SHALL hold ram_data_o from DONE until the next load capture. Stores SHALL NOT modify ram_data_o.
REQ-014 SHALL treat the request inputs as don't-care during ISSUE/DRAIN, since only registered copies are used.
REQ-015 SHALL accept a new request in IDLE on the cycle right after DONE, so back-to-back requests are supported.

Reset
REQ-016 SHALL, on rst=1 at a clock edge, set:
- state = IDLE.
- ram_data_o = 0.
- all captured request registers = 0.
- ext_ce_o = 0, ext_we_o = 0, ext_addr_o = 0, ext_data_o = 0.
REQ-017 SHALL abandon any access in progress when rst is applied mid-operation. No ext_ce_o pulse SHALL follow the reset edge.
REQ-018 SHALL force stallreq_o=0 while rst=1.

Structure
REQ-019 SHALL take bus widths (RegBus) from the shared defines file. SHALL add the FSM state encodings and the lane order/offset constants to that shared file.
REQ-020 SHALL place the lane search in one sub-module, mem_lane_pick: a combinational priority encoder over pending lanes that outputs lane index, any-pending and last-lane.
REQ-021 SHALL keep all other logic, the FSM and the capture datapath, flat in data_ram_bridge.

Verification
REQ-022 SHALL cover a full-word store:
- Stimulus: addr=0x100, sel=F, data=0x11223344.
- Required response: four ext writes at 0x100..0x103 with data 11,22,33,44; stall for 5 cycles, then DONE.
REQ-023 SHALL cover a full-word load:
- Stimulus: SRAM preloaded with 0x100..0x103 = AA,BB,CC,DD.
- Required response: ram_data_o=0xAABBCCDD in DONE, after 6 stall cycles.
REQ-024 SHALL cover a sparse byte load:
- Stimulus: sel=4'b0100 at addr 0x202.
- Required response: exactly one read at 0x201; ram_data_o=0x00XX0000; 3 stall cycles.
REQ-025 SHALL cover an empty request and back-to-back requests:
- Stimulus: sel=0 with ce=1.
- Required response: 1 stall cycle, no ext_ce_o.
- Stimulus: a store to 0x10 immediately followed by a load of 0x10.
- Required response: the load returns the stored word.
REQ-026 SHALL cover reset mid-operation:
- Stimulus: assert rst during the 2nd ISSUE cycle of a store.
- Required response: ext_ce_o=0 from the next cycle; state=IDLE; stallreq_o=0; the remaining bytes are unwritten.
